// File: rtl/axi4_lite_regfile_pkg.sv
// Register access modes and AXI response codes shared by the register-file slave.
package axi4_lite_regfile_pkg;

  typedef enum logic [1:0] {
    REG_RW    = 2'd0,
    REG_RO    = 2'd1,
    REG_W1C   = 2'd2,
    REG_PULSE = 2'd3
  } reg_mode_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_regfile_wchan.sv
// AXI4-Lite write channel: independent AW/W holding slots, commit strobe and B response.
module axi4_lite_regfile_wchan
  import axi4_lite_regfile_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int data_width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ready_en,
  input  logic [addr_width-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [data_width-1:0]   s_axi_wdata,
  input  logic [data_width/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic                    commit,
  output logic [addr_width-1:0]   commit_addr,
  output logic [2:0]              commit_prot,
  output logic [data_width-1:0]   commit_data,
  output logic [data_width/8-1:0] commit_strb,
  input  logic [1:0]              commit_resp
);

  logic aw_full;
  logic w_full;

  assign s_axi_awready = ready_en & ~aw_full;
  assign s_axi_wready  = ready_en & ~w_full;
  // An unacknowledged response blocks the next commit; the slots may still fill.
  assign commit        = aw_full & w_full & ~s_axi_bvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      commit_addr <= '0;
      commit_prot <= '0;
      commit_data <= '0;
      commit_strb <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full     <= 1'b1;
        commit_addr <= s_axi_awaddr;
        commit_prot <= s_axi_awprot;
      end else if (commit) begin
        aw_full <= 1'b0;
      end

      if (s_axi_wvalid && s_axi_wready) begin
        w_full      <= 1'b1;
        commit_data <= s_axi_wdata;
        commit_strb <= s_axi_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end

      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= commit_resp;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave owning a register file with per-register RW/RO/W1C/PULSE modes.
// Optional build macro AXI_REGFILE_PROT_CHECK_EN: unprivileged accesses (prot[0]=0) get SLVERR.
module axi4_lite_slave_regfile
  import axi4_lite_regfile_pkg::*;
#(
  parameter int                          num_regs   = 8,
  parameter int                          addr_width = 7,
  parameter int                          data_width = 32,
  parameter logic [2*num_regs-1:0]          reg_modes  = '0,
  parameter logic [num_regs*data_width-1:0] reset_vals = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [data_width-1:0]   reg_vals [num_regs],
  input  logic [data_width-1:0]   reg_hw_value [num_regs],
  input  logic [data_width-1:0]   reg_hw_set [num_regs],
  output logic [num_regs-1:0]     reg_write_pulse,
  input  logic [addr_width-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [data_width-1:0]   s_axi_wdata,
  input  logic [data_width/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [addr_width-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [data_width-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB    = data_width / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = addr_width - LSB;

  logic                  ready_en;
  logic                  commit;
  logic [addr_width-1:0] commit_addr;
  logic [2:0]            commit_prot;
  logic [data_width-1:0] commit_data;
  logic [NB-1:0]         commit_strb;
  logic [1:0]            commit_resp;
  logic [data_width-1:0] wmask;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_prot_ok;
  logic                  r_prot_ok;
  logic                  w_ok;
  logic                  r_ok;
  logic                  unused_bits;
  logic [data_width-1:0] rd_val;
  logic [data_width-1:0] reg_nxt [num_regs];
  logic [num_regs-1:0]   pulse_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  axi4_lite_regfile_wchan #(
    .addr_width (addr_width),
    .data_width (data_width)
  ) u_wchan (
    .clk           (clk),
    .rst_n         (rst_n),
    .ready_en      (ready_en),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .commit        (commit),
    .commit_addr   (commit_addr),
    .commit_prot   (commit_prot),
    .commit_data   (commit_data),
    .commit_strb   (commit_strb),
    .commit_resp   (commit_resp)
  );

  assign w_idx = commit_addr[addr_width-1:LSB];
  assign r_idx = s_axi_araddr[addr_width-1:LSB];

`ifdef AXI_REGFILE_PROT_CHECK_EN
  assign w_prot_ok   = commit_prot[0];
  assign r_prot_ok   = s_axi_arprot[0];
  assign unused_bits = ^{commit_addr[LSB-1:0], s_axi_araddr[LSB-1:0],
                         commit_prot[2:1], s_axi_arprot[2:1]};
`else
  assign w_prot_ok   = 1'b1;
  assign r_prot_ok   = 1'b1;
  assign unused_bits = ^{commit_addr[LSB-1:0], s_axi_araddr[LSB-1:0],
                         commit_prot, s_axi_arprot};
`endif

  assign w_ok        = (32'(w_idx) < num_regs) & w_prot_ok;
  assign r_ok        = (32'(r_idx) < num_regs) & r_prot_ok;
  assign commit_resp = w_ok ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) wmask[8*b +: 8] = {8{commit_strb[b]}};
  end

  for (genvar i = 0; i < num_regs; i++) begin : g_reg
    localparam reg_mode_t             MODE    = reg_mode_t'(reg_modes[2*i +: 2]);
    localparam logic [data_width-1:0] RST_VAL = reset_vals[i*data_width +: data_width];

    logic                  sel;
    logic                  pls;
    logic [data_width-1:0] nxt;

    assign sel = commit & w_ok & (w_idx == IDX_W'(i));

    always_comb begin
      nxt = reg_vals[i];
      pls = sel & (MODE != REG_RO);
      case (MODE)
        REG_RW:  if (sel) nxt = (reg_vals[i] & ~wmask) | (commit_data & wmask);
        REG_RO:  nxt = reg_hw_value[i];
        // hw set is OR-ed after the clear so it wins on a same-cycle collision
        REG_W1C: nxt = (sel ? (reg_vals[i] & ~(commit_data & wmask)) : reg_vals[i])
                       | reg_hw_set[i];
        default: nxt = sel ? ((RST_VAL & ~wmask) | (commit_data & wmask)) : RST_VAL;
      endcase
    end

    assign reg_nxt[i]   = nxt;
    assign pulse_nxt[i] = pls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_regs; i++) reg_vals[i] <= reset_vals[i*data_width +: data_width];
      reg_write_pulse <= '0;
    end else begin
      for (int i = 0; i < num_regs; i++) reg_vals[i] <= reg_nxt[i];
      reg_write_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < num_regs; i++) begin
      if (r_idx == IDX_W'(i)) rd_val = reg_vals[i];
    end
  end

  assign s_axi_arready = ready_en & ~s_axi_rvalid;

  // Sampled from the current array, so a same-edge write is not visible to this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= r_ok ? rd_val : '0;
      s_axi_rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile: 4 regs {RW,RO,W1C,PULSE}, resets {0x11,0,0xF0,0x5}.
module tb_axi4_lite_slave_regfile;
  import axi4_lite_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] reg_vals [4];
  logic [31:0] reg_hw_value [4];
  logic [31:0] reg_hw_set [4];
  logic [3:0]  reg_write_pulse;
  logic [6:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [6:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt [4] = '{default: 0};
  int          r3_cnt = 0;
  logic [31:0] r3_seen = '0;

  always #5 clk = ~clk;

  axi4_lite_slave_regfile #(
    .num_regs   (4),
    .addr_width (7),
    .data_width (32),
    .reg_modes  ({REG_PULSE, REG_W1C, REG_RO, REG_RW}),
    .reset_vals ({32'h5, 32'hF0, 32'h0, 32'h11})
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reg_vals        (reg_vals),
    .reg_hw_value    (reg_hw_value),
    .reg_hw_set      (reg_hw_set),
    .reg_write_pulse (reg_write_pulse),
    .s_axi_awaddr    (s_axi_awaddr),
    .s_axi_awprot    (s_axi_awprot),
    .s_axi_awvalid   (s_axi_awvalid),
    .s_axi_awready   (s_axi_awready),
    .s_axi_wdata     (s_axi_wdata),
    .s_axi_wstrb     (s_axi_wstrb),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .s_axi_bresp     (s_axi_bresp),
    .s_axi_bvalid    (s_axi_bvalid),
    .s_axi_bready    (s_axi_bready),
    .s_axi_araddr    (s_axi_araddr),
    .s_axi_arprot    (s_axi_arprot),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .s_axi_rdata     (s_axi_rdata),
    .s_axi_rresp     (s_axi_rresp),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready)
  );

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (reg_write_pulse[k]) pulse_cnt[k]++;
    if (reg_vals[3] !== 32'h5) begin
      r3_cnt++;
      r3_seen = reg_vals[3];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic send_aw(input logic [6:0] a, input logic [2:0] p);
    int n = 0;
    s_axi_awaddr = a; s_axi_awprot = p; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    check_val("awready", 32'(s_axi_awready), 32'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
    check_val("wready", 32'(s_axi_wready), 32'd1);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n = 0;
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check_val("bvalid", 32'(s_axi_bvalid), 32'd1);
    r = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, output logic [1:0] r);
    fork
      send_aw(a, p);
      send_w(d, s);
    join
    wait_b(r);
  endtask

  task automatic axi_read(input logic [6:0] a, input logic [2:0] p,
                          output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    s_axi_araddr = a; s_axi_arprot = p; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    check_val("arready", 32'(s_axi_arready), 32'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    check_val("rvalid", 32'(s_axi_rvalid), 32'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          psum;

    reg_hw_value = '{32'h0, 32'h12345678, 32'h0, 32'h0};
    reg_hw_set   = '{default: 32'h0};

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_awready", 32'(s_axi_awready), 32'd0);
    check_val("rst_arready", 32'(s_axi_arready), 32'd0);
    check_val("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check_val("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check_val("rst_rdata", s_axi_rdata, 32'h0);
    check_val("rst_reg0", reg_vals[0], 32'h11);
    check_val("rst_reg2", reg_vals[2], 32'hF0);
    check_val("rst_reg3", reg_vals[3], 32'h5);
    check_val("rst_pulse", 32'(reg_write_pulse), 32'h0);
    rst_n = 1'b1;
    check_val("arready_pre_edge", 32'(s_axi_arready), 32'd0);
    @(negedge clk);
    check_val("arready_post_edge", 32'(s_axi_arready), 32'd1);

    // 1: read all registers after reset
    axi_read(7'h00, 3'b001, rd, resp);
    check_val("rd0", rd, 32'h11);   check_val("rd0_resp", 32'(resp), 32'(RESP_OKAY));
    axi_read(7'h04, 3'b001, rd, resp);
    check_val("rd1", rd, 32'h12345678); check_val("rd1_resp", 32'(resp), 32'(RESP_OKAY));
    axi_read(7'h08, 3'b001, rd, resp);
    check_val("rd2", rd, 32'hF0);   check_val("rd2_resp", 32'(resp), 32'(RESP_OKAY));
    axi_read(7'h0C, 3'b001, rd, resp);
    check_val("rd3", rd, 32'h5);    check_val("rd3_resp", 32'(resp), 32'(RESP_OKAY));

    // 2: AW three cycles ahead of W, strobes lanes 0 and 2 only
    fork
      begin send_aw(7'h00, 3'b001); check_val("aw_slot_full", 32'(s_axi_awready), 32'd0); end
      begin repeat (3) @(negedge clk); send_w(32'hAABBCCDD, 4'b0101); end
    join
    wait_b(resp);
    check_val("wr_a_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("wr_a_reg0", reg_vals[0], 32'h00BB00DD);
    check_val("wr_a_pulse", 32'(pulse_cnt[0]), 32'd1);
    fork
      begin send_w(32'h01020304, 4'hF); check_val("w_slot_full", 32'(s_axi_wready), 32'd0); end
      begin repeat (2) @(negedge clk); send_aw(7'h00, 3'b001); end
    join
    wait_b(resp);
    check_val("wr_b_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("wr_b_reg0", reg_vals[0], 32'h01020304);
    check_val("wr_b_pulse", 32'(pulse_cnt[0]), 32'd2);

    // 3: W1C with a colliding hw set on bit 4
    reg_hw_set[2] = 32'h10;
    axi_write(7'h08, 32'h30, 4'hF, 3'b001, resp);
    reg_hw_set[2] = 32'h0;
    check_val("w1c_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("w1c_reg2", reg_vals[2], 32'hD0);
    axi_write(7'h08, 32'h80, 4'hF, 3'b001, resp);
    check_val("w1c_reg2_b", reg_vals[2], 32'h50);
    check_val("w1c_pulse", 32'(pulse_cnt[2]), 32'd2);

    // 4: PULSE, RO write, decode misses, low address bits
    axi_write(7'h0C, 32'h1, 4'hF, 3'b001, resp);
    check_val("pls_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("pls_cycles", 32'(r3_cnt), 32'd1);
    check_val("pls_value", r3_seen, 32'h1);
    check_val("pls_back", reg_vals[3], 32'h5);
    check_val("pls_pulse", 32'(pulse_cnt[3]), 32'd1);
    axi_write(7'h04, 32'hFFFF, 4'hF, 3'b001, resp);
    check_val("ro_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("ro_nopulse", 32'(pulse_cnt[1]), 32'd0);
    check_val("ro_reg1", reg_vals[1], 32'h12345678);
    psum = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    axi_write(7'h10, 32'hFFFF_FFFF, 4'hF, 3'b001, resp);
    check_val("miss_resp", 32'(resp), 32'(RESP_SLVERR));
    check_val("miss_nopulse", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'(psum));
    check_val("miss_reg0", reg_vals[0], 32'h01020304);
    axi_read(7'h14, 3'b001, rd, resp);
    check_val("rdmiss_data", rd, 32'h0);
    check_val("rdmiss_resp", 32'(resp), 32'(RESP_SLVERR));
    axi_read(7'h03, 3'b001, rd, resp);
    check_val("rd_lowbits", rd, 32'h01020304);
    reg_hw_value[1] = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    axi_read(7'h04, 3'b001, rd, resp);
    check_val("rd_ro_follow", rd, 32'hCAFEF00D);

    // 5: second write held behind an unacknowledged response
    fork send_aw(7'h00, 3'b001); send_w(32'h11111111, 4'hF); join
    fork send_aw(7'h00, 3'b001); send_w(32'h22222222, 4'hF); join
    repeat (3) @(negedge clk);
    check_val("hold_reg0", reg_vals[0], 32'h11111111);
    check_val("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
    check_val("hold_awready", 32'(s_axi_awready), 32'd0);
    wait_b(resp);
    check_val("hold_b1_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("hold_b1_reg0", reg_vals[0], 32'h11111111);
    wait_b(resp);
    check_val("hold_b2_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("hold_b2_reg0", reg_vals[0], 32'h22222222);

    // read and write commit on the same edge, then reset with both responses pending
    fork send_aw(7'h00, 3'b001); send_w(32'hDEAD0000, 4'hF); join
    s_axi_araddr = 7'h00; s_axi_arprot = 3'b001; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check_val("rw_same_edge", s_axi_rdata, 32'h22222222);
    check_val("rw_reg0", reg_vals[0], 32'hDEAD0000);
    check_val("pend_bvalid", 32'(s_axi_bvalid), 32'd1);
    check_val("pend_rvalid", 32'(s_axi_rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check_val("arst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check_val("arst_rdata", s_axi_rdata, 32'h0);
    check_val("arst_reg0", reg_vals[0], 32'h11);
    check_val("arst_reg2", reg_vals[2], 32'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 6: protection check
`ifdef AXI_REGFILE_PROT_CHECK_EN
    axi_write(7'h00, 32'h0000ABCD, 4'hF, 3'b000, resp);
    check_val("prot0_resp", 32'(resp), 32'(RESP_SLVERR));
    check_val("prot0_reg0", reg_vals[0], 32'h11);
    axi_write(7'h00, 32'h0000ABCD, 4'hF, 3'b001, resp);
    check_val("prot1_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("prot1_reg0", reg_vals[0], 32'h0000ABCD);
    axi_read(7'h00, 3'b000, rd, resp);
    check_val("prot_rd_data", rd, 32'h0);
    check_val("prot_rd_resp", 32'(resp), 32'(RESP_SLVERR));
`else
    axi_write(7'h00, 32'h0000ABCD, 4'hF, 3'b000, resp);
    check_val("noprot_resp", 32'(resp), 32'(RESP_OKAY));
    check_val("noprot_reg0", reg_vals[0], 32'h0000ABCD);
    axi_read(7'h00, 3'b000, rd, resp);
    check_val("noprot_rd_data", rd, 32'h0000ABCD);
    check_val("noprot_rd_resp", 32'(resp), 32'(RESP_OKAY));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
